// File: rtl/lf_pkg.sv
// ============================================================================
// Module      : lf_pkg
// Description : Shared Ladner-Fischer types and helpers for the adder and
//               subtractor family: (g,p) pair, prefix combine operator, clog2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lf_pkg;

    localparam int LF_WIDTH_DEFAULT = 16;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Prefix operator: hi covers the more significant span, lo the one below it.
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t res;
        res.g = hi.g | (hi.p & lo.g);
        res.p = hi.p & lo.p;
        return res;
    endfunction

    function automatic int lf_clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lf_sub_pipe_if.sv
// ============================================================================
// Module      : lf_sub_pipe_if
// Description : Operand and result valid/ready streams of the LF subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lf_sub_pipe_if
    import lf_pkg::*;
#(
    parameter int WIDTH = LF_WIDTH_DEFAULT
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );

endinterface

`default_nettype wire

// File: rtl/lf_prefix_tree.sv
// ============================================================================
// Module      : lf_prefix_tree
// Description : Combinational Ladner-Fischer (G,P) prefix tree; bit i of the
//               outputs is the group generate/propagate over span [i:0].
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lf_prefix_tree
    import lf_pkg::*;
#(
    parameter int WIDTH = LF_WIDTH_DEFAULT
)
(
    input  logic [WIDTH-1:0] i_g,
    input  logic [WIDTH-1:0] i_p,
    output logic [WIDTH-1:0] o_grp_g,
    output logic [WIDTH-1:0] o_grp_p
);

    localparam int c_levels = lf_clog2(WIDTH);

    // Row 0 is the input, rows 1..c_levels+1 are the prefix levels.
    gp_t w_node [c_levels+2][WIDTH];

    always_comb begin : p_tree
        int j;
        j = 0;
        for (int l = 0; l < c_levels + 2; l++) begin
            for (int i = 0; i < WIDTH; i++) begin
                w_node[l][i] = '0;
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            w_node[0][i].g = i_g[i];
            w_node[0][i].p = i_p[i];
        end

        // Sparse stage: odd positions absorb their even neighbour.
        for (int i = 0; i < WIDTH; i++) begin
            w_node[1][i] = w_node[0][i];
            if ((i % 2) == 1) begin
                w_node[1][i] = gp_combine(w_node[0][i], w_node[0][i-1]);
            end
        end

        // Sklansky doubling over the odd positions only.
        for (int l = 1; l < c_levels; l++) begin
            for (int i = 0; i < WIDTH; i++) begin
                w_node[l+1][i] = w_node[l][i];
                j = ((i >> l) << l) - 1;
                if (j < 0) begin
                    j = 0;
                end
                if (((i % 2) == 1) && (((i >> l) & 1) == 1)) begin
                    w_node[l+1][i] = gp_combine(w_node[l][i], w_node[l][j]);
                end
            end
        end

        // Fan-out: even positions pick up the completed prefix just below.
        for (int i = 0; i < WIDTH; i++) begin
            w_node[c_levels+1][i] = w_node[c_levels][i];
            if (((i % 2) == 0) && (i > 0)) begin
                w_node[c_levels+1][i] = gp_combine(w_node[c_levels][i], w_node[c_levels][i-1]);
            end
        end

        for (int i = 0; i < WIDTH; i++) begin
            o_grp_g[i] = w_node[c_levels+1][i].g;
            o_grp_p[i] = w_node[c_levels+1][i].p;
        end
    end

endmodule

`default_nettype wire

// File: rtl/lf_sub_pipe.sv
// ============================================================================
// Module      : lf_sub_pipe
// Description : Three-stage pipelined Ladner-Fischer subtractor,
//               diff = a - b - bin, with borrow-out and signed overflow.
//               Define LF_SUB_APPROX_EN for generate-only carries in the low
//               APPROX_BITS bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lf_sub_pipe
    import lf_pkg::*;
#(
    parameter int WIDTH       = LF_WIDTH_DEFAULT,
    parameter int APPROX_BITS = 4
)
(
    input  logic          clk,
    input  logic          rst_n,
    lf_sub_pipe_if.slave  bus
);

`ifdef LF_SUB_APPROX_EN
    localparam bit c_approx_en = 1'b1;
`else
    localparam bit c_approx_en = 1'b0;
`endif
    localparam int c_approx_bits = c_approx_en ? APPROX_BITS : 0;

    // Handshake
    logic w_s3_ready;
    logic w_s2_ready;
    logic w_s2_adv;
    logic w_s1_adv;
    logic w_s1_ready;
    logic w_accept;

    logic r_s1_valid;
    logic r_s2_valid;
    logic r_s3_valid;

    // Stage 1: a + ~b + ~bin in (p,g) form
    logic [WIDTH-1:0] r_s1_p;
    logic [WIDTH-1:0] r_s1_g;
    logic             r_s1_cin;
    logic             r_s1_amsb;
    logic             r_s1_bmsb;

    // Stage 2: group prefixes
    logic [WIDTH-1:0] w_tree_g;
    logic [WIDTH-1:0] w_tree_p;
    logic [WIDTH-1:0] w_grp_g;
    logic [WIDTH-1:0] w_grp_p;
    logic [WIDTH-1:0] r_s2_gg;
    logic [WIDTH-1:0] r_s2_pp;
    logic [WIDTH-1:0] r_s2_p;
    logic             r_s2_cin;
    logic             r_s2_amsb;
    logic             r_s2_bmsb;
`ifdef LF_SUB_APPROX_EN
    logic [APPROX_BITS-1:0] r_s2_glo;
`endif

    // Stage 3: result
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_diff;
    logic             w_bout;
    logic             w_ovf;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;

    assign w_s3_ready = ~r_s3_valid | bus.out_ready;
    assign w_s2_adv   = r_s2_valid & w_s3_ready;
    assign w_s2_ready = ~r_s2_valid | w_s3_ready;
    assign w_s1_adv   = r_s1_valid & w_s2_ready;
    assign w_s1_ready = ~r_s1_valid | w_s1_adv;
    assign w_accept   = bus.in_valid & w_s1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            r_diff     <= '0;
            r_bout     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_s1_valid <= w_accept | (r_s1_valid & ~w_s2_ready);
            r_s2_valid <= w_s1_adv | (r_s2_valid & ~w_s3_ready);
            r_s3_valid <= w_s2_adv | (r_s3_valid & ~bus.out_ready);
            if (w_s2_adv) begin
                r_diff <= w_diff;
                r_bout <= w_bout;
                r_ovf  <= w_ovf;
            end
        end
    end

    // In-flight data only moves with its valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_p    <= bus.a ^ ~bus.b;
            r_s1_g    <= bus.a & ~bus.b;
            r_s1_cin  <= ~bus.bin;
            r_s1_amsb <= bus.a[WIDTH-1];
            r_s1_bmsb <= bus.b[WIDTH-1];
        end
        if (w_s1_adv) begin
            r_s2_gg   <= w_grp_g;
            r_s2_pp   <= w_grp_p;
            r_s2_p    <= r_s1_p;
            r_s2_cin  <= r_s1_cin;
            r_s2_amsb <= r_s1_amsb;
            r_s2_bmsb <= r_s1_bmsb;
`ifdef LF_SUB_APPROX_EN
            r_s2_glo  <= r_s1_g[APPROX_BITS-1:0];
`endif
        end
    end

    // In the approximate build the low region is cut out of the tree: the top
    // approximate bit becomes a pure generate seed (p=0), so cin cannot reach
    // the exact upper region and its carry-in is g[APPROX_BITS-1].
    always_comb begin
        w_tree_g = r_s1_g;
        w_tree_p = r_s1_p;
        for (int i = 0; i < c_approx_bits; i++) begin
            w_tree_p[i] = 1'b0;
            if (i != c_approx_bits - 1) begin
                w_tree_g[i] = 1'b0;
            end
        end
    end

    lf_prefix_tree #(
        .WIDTH   (WIDTH)
    ) u_tree (
        .i_g     (w_tree_g),
        .i_p     (w_tree_p),
        .o_grp_g (w_grp_g),
        .o_grp_p (w_grp_p)
    );

    always_comb begin
        w_c    = '0;
        w_c[0] = r_s2_cin;
        for (int i = 0; i < WIDTH; i++) begin
            w_c[i+1] = r_s2_gg[i] | (r_s2_pp[i] & r_s2_cin);
        end
`ifdef LF_SUB_APPROX_EN
        for (int i = 0; i < c_approx_bits; i++) begin
            w_c[i+1] = r_s2_glo[i];
        end
`endif
        w_diff = r_s2_p ^ w_c[WIDTH-1:0];
        w_bout = ~w_c[WIDTH];
        w_ovf  = (r_s2_amsb ^ r_s2_bmsb) & (r_s2_amsb ^ w_diff[WIDTH-1]);
    end

    assign bus.in_ready  = w_s1_ready;
    assign bus.out_valid = r_s3_valid;
    assign bus.diff      = r_diff;
    assign bus.bout      = r_bout;
    assign bus.ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_lf_sub_pipe.sv
// ============================================================================
// Module      : tb_lf_sub_pipe
// Description : Directed self-checking bench for lf_sub_pipe (WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lf_sub_pipe;

    localparam int WIDTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    lf_sub_pipe_if #(.WIDTH(WIDTH)) bus ();

    lf_sub_pipe #(
        .WIDTH       (WIDTH),
        .APPROX_BITS (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          idx;
    logic        acc;
    logic [15:0] stream_a [5];
    logic [15:0] stream_d [5];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic present(input int k);
        if (k < 5) begin
            bus.in_valid = 1'b1;
            bus.a        = stream_a[k];
            bus.b        = 16'h000F;
            bus.bin      = 1'b1;
        end else begin
            bus.in_valid = 1'b0;
        end
    endtask

    // One beat into an empty pipe with out_ready=1; result must appear 3 cycles on.
    task automatic run_one(input string tag, input logic [15:0] av, input logic [15:0] bv,
                           input logic binv, input logic [15:0] ed, input logic eb,
                           input logic eo);
        int lat;
        bus.a         = av;
        bus.b         = bv;
        bus.bin       = binv;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_diff"}, 32'(bus.diff), 32'(ed));
        check({tag, "_bout"}, 32'(bus.bout), 32'(eb));
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
        @(negedge clk);
    endtask

    initial begin
        stream_a[0] = 16'h1110; stream_d[0] = 16'h1100;
        stream_a[1] = 16'h2220; stream_d[1] = 16'h2210;
        stream_a[2] = 16'h3330; stream_d[2] = 16'h3320;
        stream_a[3] = 16'h4440; stream_d[3] = 16'h4430;
        stream_a[4] = 16'h5550; stream_d[4] = 16'h5540;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_bout", 32'(bus.bout), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);
        check("idle_out_valid", 32'(bus.out_valid), 32'd0);

`ifdef LF_SUB_APPROX_EN
        run_one("sub_5_3", 16'h0005, 16'h0003, 1'b0, 16'hFFF0, 1'b1, 1'b0);
`else
        run_one("sub_5_3", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
`endif
        run_one("sub_0_1", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_one("sub_0_0_bin", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_one("sub_8000_1", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
`ifdef LF_SUB_APPROX_EN
        run_one("sub_7fff_ffff", 16'h7FFF, 16'hFFFF, 1'b0, 16'h7FFE, 1'b1, 1'b0);
        run_one("sub_0010_0", 16'h0010, 16'h0000, 1'b0, 16'h000E, 1'b0, 1'b0);
`else
        run_one("sub_7fff_ffff", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
        run_one("sub_0010_0", 16'h0010, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b0);
`endif

        // Back-pressure: five beats offered, consumer stalled for six cycles.
        bus.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            present(idx);
            #1;
            if (c >= 3) begin
                check("stall_out_valid", 32'(bus.out_valid), 32'd1);
                check("stall_hold_diff", 32'(bus.diff), 32'(stream_d[0]));
                check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            end
            acc = bus.in_valid & bus.in_ready;
            @(negedge clk);
            if (acc) idx++;
        end
        check("stall_accepted", 32'(idx), 32'd3);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            present(idx);
            #1;
            check("drain_out_valid", 32'(bus.out_valid), 32'd1);
            check("drain_order", 32'(bus.diff), 32'(stream_d[k]));
            acc = bus.in_valid & bus.in_ready;
            @(negedge clk);
            if (acc) idx++;
        end
        #1;
        check("drain_empty", 32'(bus.out_valid), 32'd0);
        check("drain_accepted", 32'(idx), 32'd5);

        // Reset with three beats in flight.
        bus.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 3; c++) begin
            present(idx);
            #1;
            acc = bus.in_valid & bus.in_ready;
            @(negedge clk);
            if (acc) idx++;
        end
        bus.in_valid = 1'b0;
        #1;
        check("inflight_out_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_diff", 32'(bus.diff), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            check("postrst_no_stale", 32'(bus.out_valid), 32'd0);
        end
        run_one("postrst_sub", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
